// File: rtl/asip_decode_pkg.sv
// Shared definitions for the scalar decode stage.
// Holds the opcode constants, the bit positions of each instruction field,
// the decode FSM state type and a helper that tells whether an opcode writes rd.
package asip_decode_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction layout: [15:12] opcode, [11:10] rd, [9:8] rs1, [7:6] rs2, [5:0] imm
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RD_LSB     = 10;
    localparam int unsigned RS1_LSB    = 8;
    localparam int unsigned RS2_LSB    = 6;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned IMM_WIDTH  = 6;
    localparam int unsigned WRFLAG_BIT = 3;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } decode_state_t;

    function automatic logic writes_rd(input logic [3:0] opcode);
        return opcode[WRFLAG_BIT];
    endfunction

endpackage

// File: rtl/scalar_decode_stage_scoreboard.sv
// Pending-write scoreboard for the scalar register file.
// Ports:
//   clk_i, rst_ni          clock and synchronous active-low reset
//   set_i, set_reg_i       mark a register as having a write in flight
//   clr_i, clr_reg_i       writeback completed for a register
//   rs1_i, rs2_i, rd_i     registers to look up
//   rs1_pend_o, rs2_pend_o, rd_pend_o  lookup results (current, pre-edge mask)
//   any_pend_o             at least one write still in flight
module scoreboard #(
    parameter int unsigned Quantity = 4,
    parameter int unsigned SelBits  = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               set_i,
    input  logic [SelBits-1:0] set_reg_i,
    input  logic               clr_i,
    input  logic [SelBits-1:0] clr_reg_i,
    input  logic [SelBits-1:0] rs1_i,
    input  logic [SelBits-1:0] rs2_i,
    input  logic [SelBits-1:0] rd_i,
    output logic               rs1_pend_o,
    output logic               rs2_pend_o,
    output logic               rd_pend_o,
    output logic               any_pend_o
);

    logic [Quantity-1:0] pending_q, pending_d;

    // Clear first, then set, so a same-edge writeback never wipes a fresh claim.
    // Clearing an already-clear bit is harmless, which covers stray writebacks.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_reg_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_reg_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Lookups use the registered mask: no bypass of a writeback landing this edge.
    assign rs1_pend_o = pending_q[rs1_i];
    assign rs2_pend_o = pending_q[rs2_i];
    assign rd_pend_o  = pending_q[rd_i];
    assign any_pend_o = |pending_q;

endmodule

// File: rtl/scalar_decode_stage.sv
// Scalar decode stage between fetch and execute.
// Splits 16-bit instructions into fields, drives the register file read selects,
// stalls on scoreboard hazards and registers decoded instruction plus operands.
// A HALT opcode is swallowed, outstanding writes drain, then the stage parks.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   inValid/inInstr/inReady     fetch handshake
//   rSel1, rSel2                register file read selects (rs1/rs2 of inInstr)
//   reg1Data, reg2Data          register file read data
//   wbValid, wbReg              register write happening at this edge
//   outValid/outReady           execute handshake
//   outOpcode, outRd, outWrEn, outOp1, outOp2, outImm   decoded instruction
//   halted                      stage parked after HALT
module scalar_decode_stage
    import asip_decode_pkg::*;
#(
    parameter int unsigned registerSize     = 8,
    parameter int unsigned registerQuantity = 4,
    parameter int unsigned selectionBits    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    input  logic [15:0]              inInstr,
    output logic                     inReady,
    output logic [selectionBits-1:0] rSel1,
    output logic [selectionBits-1:0] rSel2,
    input  logic [registerSize-1:0]  reg1Data,
    input  logic [registerSize-1:0]  reg2Data,
    input  logic                     wbValid,
    input  logic [selectionBits-1:0] wbReg,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [3:0]               outOpcode,
    output logic [selectionBits-1:0] outRd,
    output logic                     outWrEn,
    output logic [registerSize-1:0]  outOp1,
    output logic [registerSize-1:0]  outOp2,
    output logic [registerSize-1:0]  outImm,
    output logic                     halted
);

    // Field split
    logic [3:0]               opcode;
    logic [selectionBits-1:0] rd, rs1, rs2;
    logic [IMM_WIDTH-1:0]     imm6;
    logic [registerSize-1:0]  imm_ext;
    logic                     wr_flag, is_halt;

    assign opcode  = inInstr[OPCODE_LSB +: 4];
    assign rd      = inInstr[RD_LSB +: selectionBits];
    assign rs1     = inInstr[RS1_LSB +: selectionBits];
    assign rs2     = inInstr[RS2_LSB +: selectionBits];
    assign imm6    = inInstr[IMM_LSB +: IMM_WIDTH];
    assign imm_ext = {{(registerSize - IMM_WIDTH){imm6[IMM_WIDTH-1]}}, imm6};
    assign wr_flag = writes_rd(opcode);
    assign is_halt = (opcode == OP_HALT);

    assign rSel1 = rs1;
    assign rSel2 = rs2;

    // Scoreboard
    logic rs1_pend, rs2_pend, rd_pend, any_pend;
    logic hazard, issue, accept, out_free;

    scoreboard #(
        .Quantity (registerQuantity),
        .SelBits  (selectionBits)
    ) u_scoreboard (
        .clk_i      (clk),
        .rst_ni     (reset),
        .set_i      (issue & wr_flag),
        .set_reg_i  (rd),
        .clr_i      (wbValid),
        .clr_reg_i  (wbReg),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rd_i       (rd),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .rd_pend_o  (rd_pend),
        .any_pend_o (any_pend)
    );

    assign hazard = rs1_pend | rs2_pend | (wr_flag & rd_pend);

    // FSM: state register
    decode_state_t state_q, state_d;
    logic          out_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept && is_halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!any_pend && !out_valid_q) begin
                    state_d = HALTED;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    assign out_free = ~out_valid_q | outReady;

    always_comb begin
        inReady = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            RUN:     inReady = reset & ~hazard & out_free;
            DRAIN:   inReady = 1'b0;
            HALTED:  halted  = 1'b1;
            default: inReady = 1'b0;
        endcase
    end

    assign accept = inValid & inReady;
    // HALT is consumed here and never reaches execute
    assign issue  = accept & ~is_halt;

    // Output register
    logic [3:0]               out_opcode_q;
    logic [selectionBits-1:0] out_rd_q;
    logic                     out_wr_en_q;
    logic [registerSize-1:0]  out_op1_q, out_op2_q, out_imm_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_opcode_q <= '0;
            out_rd_q     <= '0;
            out_wr_en_q  <= 1'b0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_imm_q    <= '0;
        end else if (issue) begin
            out_valid_q  <= 1'b1;
            out_opcode_q <= opcode;
            out_rd_q     <= rd;
            out_wr_en_q  <= wr_flag;
            out_op1_q    <= reg1Data;
            out_op2_q    <= reg2Data;
            out_imm_q    <= imm_ext;
        end else if (outReady) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign outValid  = out_valid_q;
    assign outOpcode = out_opcode_q;
    assign outRd     = out_rd_q;
    assign outWrEn   = out_wr_en_q;
    assign outOp1    = out_op1_q;
    assign outOp2    = out_op2_q;
    assign outImm    = out_imm_q;

endmodule

// File: tb/tb_scalar_decode_stage.sv
// Directed bench for scalar_decode_stage with a small register file model.
module tb_scalar_decode_stage;

    logic       clk;
    logic       reset;
    logic       inValid;
    logic [15:0] inInstr;
    logic       inReady;
    logic [1:0] rSel1, rSel2;
    logic [7:0] reg1Data, reg2Data;
    logic       wbValid;
    logic [1:0] wbReg;
    logic [7:0] wbData;
    logic       outValid;
    logic       outReady;
    logic [3:0] outOpcode;
    logic [1:0] outRd;
    logic       outWrEn;
    logic [7:0] outOp1, outOp2, outImm;
    logic       halted;

    logic [7:0] rf [4];

    int total;
    int bad;

    assign reg1Data = rf[rSel1];
    assign reg2Data = rf[rSel2];

    scalar_decode_stage #(
        .registerSize     (8),
        .registerQuantity (4),
        .selectionBits    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .inValid   (inValid),
        .inInstr   (inInstr),
        .inReady   (inReady),
        .rSel1     (rSel1),
        .rSel2     (rSel2),
        .reg1Data  (reg1Data),
        .reg2Data  (reg2Data),
        .wbValid   (wbValid),
        .wbReg     (wbReg),
        .outValid  (outValid),
        .outReady  (outReady),
        .outOpcode (outOpcode),
        .outRd     (outRd),
        .outWrEn   (outWrEn),
        .outOp1    (outOp1),
        .outOp2    (outOp2),
        .outImm    (outImm),
        .halted    (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock; register file write lands just after the edge, as in the real RF.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wbValid) rf[wbReg] = wbData;
        wbValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; inValid = 1'b0; inInstr = 16'h0000; outReady = 1'b1;
        wbValid = 1'b0; wbReg = 2'd0; wbData = 8'h00;
        rf[0] = 8'h34; rf[1] = 8'h12; rf[2] = 8'h00; rf[3] = 8'h00;
        tick();
        tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL reset_outValid got %b want 0", outValid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got %b want 0", halted); end
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL reset_inReady got %b want 0", inReady); end
        total++; if ({outOp1, outOp2, outImm} !== 24'h0) begin bad++; $display("FAIL reset_data got %h want 000000", {outOp1, outOp2, outImm}); end
        total++; if ({outOpcode, outRd, outWrEn} !== 7'h0) begin bad++; $display("FAIL reset_ctrl got %h want 00", {outOpcode, outRd, outWrEn}); end
        reset = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL post_reset_inReady got %b want 1", inReady); end
    endtask

    task automatic test_issue_raw();
        inValid = 1'b1; inInstr = 16'h8500;  // opcode 8, rd=1, rs1=1, rs2=0
        #1;
        total++; if ({rSel1, rSel2} !== 4'b0100) begin bad++; $display("FAIL issue_rsel got %b want 0100", {rSel1, rSel2}); end
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL issue_inReady got %b want 1", inReady); end
        tick();
        total++; if (outValid !== 1'b1) begin bad++; $display("FAIL issue_outValid got %b want 1", outValid); end
        total++; if (outOp1 !== 8'h12) begin bad++; $display("FAIL issue_op1 got %h want 12", outOp1); end
        total++; if (outOp2 !== 8'h34) begin bad++; $display("FAIL issue_op2 got %h want 34", outOp2); end
        total++; if ({outOpcode, outRd, outWrEn} !== {4'h8, 2'd1, 1'b1}) begin bad++; $display("FAIL issue_ctrl got %h/%0d/%b want 8/1/1", outOpcode, outRd, outWrEn); end
        inInstr = 16'h1100;  // opcode 1 reads r1, no write
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL raw_stall got %b want 0", inReady); end
        total++; if (rSel1 !== 2'd1) begin bad++; $display("FAIL raw_rsel_stall got %0d want 1", rSel1); end
        tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL raw_drop got %b want 0", outValid); end
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL raw_still_stall got %b want 0", inReady); end
        wbValid = 1'b1; wbReg = 2'd1; wbData = 8'h56;
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL raw_no_bypass got %b want 0", inReady); end
        tick();
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL raw_release got %b want 1", inReady); end
        tick();
        total++; if (outValid !== 1'b1 || outOp1 !== 8'h56) begin bad++; $display("FAIL raw_newval got %b/%h want 1/56", outValid, outOp1); end
        total++; if ({outOpcode, outWrEn} !== {4'h1, 1'b0}) begin bad++; $display("FAIL raw_ctrl got %h/%b want 1/0", outOpcode, outWrEn); end
    endtask

    task automatic test_imm();
        inInstr = 16'h0020;
        tick();
        total++; if (outImm !== 8'hE0) begin bad++; $display("FAIL imm_neg got %h want e0", outImm); end
        total++; if (outOpcode !== 4'h0 || outValid !== 1'b1) begin bad++; $display("FAIL imm_nop got %h/%b want 0/1", outOpcode, outValid); end
        inInstr = 16'h001F;
        tick();
        total++; if (outImm !== 8'h1F) begin bad++; $display("FAIL imm_pos got %h want 1f", outImm); end
        inValid = 1'b0;
        tick();
        total++; if (outValid !== 1'b0) begin bad++; $display("FAIL imm_idle got %b want 0", outValid); end
    endtask

    task automatic test_backpressure();
        outReady = 1'b0; inValid = 1'b1; inInstr = 16'h0003;
        tick();
        total++; if (outValid !== 1'b1 || outImm !== 8'h03) begin bad++; $display("FAIL bp_load got %b/%h want 1/03", outValid, outImm); end
        inInstr = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (inReady !== 1'b0) begin bad++; $display("FAIL bp_inReady[%0d] got %b want 0", i, inReady); end
            tick();
            total++; if (outValid !== 1'b1 || outImm !== 8'h03) begin bad++; $display("FAIL bp_hold[%0d] got %b/%h want 1/03", i, outValid, outImm); end
        end
        outReady = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL bp_release got %b want 1", inReady); end
        tick();
        total++; if (outImm !== 8'h04 || outValid !== 1'b1) begin bad++; $display("FAIL bp_next got %h/%b want 04/1", outImm, outValid); end
        inInstr = 16'h0005;
        tick();
        total++; if (outImm !== 8'h05 || outValid !== 1'b1) begin bad++; $display("FAIL bp_b2b got %h/%b want 05/1", outImm, outValid); end
        inValid = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        inValid = 1'b1; inInstr = 16'h8800;  // writer of r2
        tick();
        total++; if (outRd !== 2'd2 || outValid !== 1'b1) begin bad++; $display("FAIL halt_writer got %0d/%b want 2/1", outRd, outValid); end
        inInstr = 16'hF000;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL halt_accept got %b want 1", inReady); end
        tick();
        total++; if (outValid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL halt_consumed got %b/%b want 0/0", outValid, halted); end
        inInstr = 16'h0001;
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL drain_inReady got %b want 0", inReady); end
        tick();
        total++; if (halted !== 1'b0 || outValid !== 1'b0) begin bad++; $display("FAIL drain_wait got %b/%b want 0/0", halted, outValid); end
        wbValid = 1'b1; wbReg = 2'd2; wbData = 8'h77;
        tick();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL drain_wb_edge got %b want 0", halted); end
        tick();
        total++; if (halted !== 1'b1 || inReady !== 1'b0) begin bad++; $display("FAIL halted_enter got %b/%b want 1/0", halted, inReady); end
        tick();
        tick();
        total++; if (halted !== 1'b1 || outValid !== 1'b0) begin bad++; $display("FAIL halted_stay got %b/%b want 1/0", halted, outValid); end
        reset = 1'b0;
        tick();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got %b want 0", halted); end
        reset = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL halt_rerun got %b want 1", inReady); end
        inValid = 1'b0;
        tick();
    endtask

    task automatic test_same_edge();
        inValid = 1'b1; inInstr = 16'h8C00;  // writer of r3
        tick();
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL waw_stall got %b want 0", inReady); end
        wbValid = 1'b1; wbReg = 2'd3; wbData = 8'h09;
        tick();
        // stray writeback for r3 on the same edge as the new writer issues
        wbValid = 1'b1; wbReg = 2'd3; wbData = 8'h0A;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL waw_release got %b want 1", inReady); end
        tick();
        inInstr = 16'h0300;  // reader of r3
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("FAIL same_edge_pending got %b want 0", inReady); end
        // reset mid-stall wipes the scoreboard
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++; if (inReady !== 1'b1 || outValid !== 1'b0) begin bad++; $display("FAIL stall_reset got %b/%b want 1/0", inReady, outValid); end
        inValid = 1'b0;
        wbValid = 1'b1; wbReg = 2'd3; wbData = 8'h0B;
        tick();
        inValid = 1'b1;
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("FAIL late_wb_ignored got %b want 1", inReady); end
        tick();
        total++; if (outValid !== 1'b1 || outOp1 !== 8'h0B) begin bad++; $display("FAIL post_reset_issue got %b/%h want 1/0b", outValid, outOp1); end
        inValid = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_issue_raw();
        test_imm();
        test_backpressure();
        test_halt();
        test_same_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
